wishbone_bus_if: RTL
====================

// Module: wishbone_bus_if
// PURPOSE
//  Bridges one CPU pipeline memory port (instruction fetch or MEM stage) of the openmips core onto a
//  Wishbone B.3 classic master bus inside openmips_min_sopc. Holds the pipeline via stallreq_o until
//  the slave acks, latches read data while the pipeline remains stalled by other stages, and honours
//  flush (exception) by aborting the cycle. Adds a bus-timeout watchdog that ends hung transfers.
// PARAMETERS
//  ADDR_W      32  Wishbone / CPU address width
//  DATA_W      32  data width; SEL_W = DATA_W/8 byte selects
//  STALL_W     6   width of pipeline stall vector (pc,if,id,ex,mem,wb)
//  TIMEOUT_CYC 255 max cycles in BUSY waiting for ack; 0 = watchdog disabled
// PORTS
//  clk               in   1        clock, all state on rising edge
//  rst               in   1        synchronous, active-high reset (`RstEnable)
//  stall_i           in   STALL_W  pipeline stall vector from ctrl
//  flush_i           in   1        pipeline flush (exception) from ctrl
//  cpu_ce_i          in   1        CPU requests an access this cycle
//  cpu_addr_i        in   ADDR_W   access address
//  cpu_data_i        in   DATA_W   write data
//  cpu_we_i          in   1        1 = write, 0 = read
//  cpu_sel_i         in   SEL_W    byte lane selects
//  cpu_data_o        out  DATA_W   read data to pipeline (combinational)
//  stallreq_o        out  1        stall request to ctrl (combinational)
//  bus_err_o         out  1        1-cycle pulse: transfer aborted by watchdog
//  wb_data_i         in   DATA_W   Wishbone DAT_I
//  wb_ack_i          in   1        Wishbone ACK_I
//  wb_addr_o         out  ADDR_W   Wishbone ADR_O (registered)
//  wb_data_o         out  DATA_W   Wishbone DAT_O (registered)
//  wb_we_o           out  1        Wishbone WE_O (registered)
//  wb_sel_o          out  SEL_W    Wishbone SEL_O (registered)
//  wb_stb_o          out  1        Wishbone STB_O (registered)
//  wb_cyc_o          out  1        Wishbone CYC_O (registered)
// BEHAVIOUR
//  - Reset: state=IDLE; all wb_*_o = 0; rd_buf = 0; timeout count = 0; bus_err_o = 0.
//  - States: IDLE, BUSY, WAIT_FOR_STALL (2-bit encoding).
//  - IDLE: if cpu_ce_i && !flush_i -> register addr/data/we/sel, stb=cyc=1, cnt=0, go BUSY.
//    stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
//  - BUSY, wb_ack_i=1: clear stb/cyc/addr/data/we/sel; on read, rd_buf <= wb_data_i;
//    next = (stall_i != 0) ? WAIT_FOR_STALL : IDLE. Same cycle: stallreq_o = 0,
//    cpu_data_o = we ? 0 : wb_data_i (read data forwarded combinationally, 0 extra latency).
//  - BUSY, no ack: stallreq_o = 1, cpu_data_o = 0, cnt++.
//  - BUSY, flush_i=1 and no ack: abort: clear wb outputs, rd_buf = 0, go IDLE. Ack wins over flush.
//  - BUSY, TIMEOUT_CYC != 0 and cnt == TIMEOUT_CYC-1 and no ack: abort as flush, bus_err_o = 1
//    next cycle for exactly 1 cycle, cpu_data_o = 0 and stallreq_o = 0 in that cycle.
//  - WAIT_FOR_STALL: stallreq_o = 0, cpu_data_o = rd_buf; stall_i == 0 -> IDLE. New cpu_ce_i ignored
//    here (pipeline is still stalled; request is the same instruction).
//  - Minimum access: 1 cycle request + 1 cycle ack => 2 cycles stalled-to-released per transfer.
//  - stb/cyc never drop without ack, flush or timeout; wb outputs stable while stb=1 and no ack.
//  - rst asserted mid-transfer: all outputs to reset values next edge, no ack tracked afterward.
// STRUCTURE
//  - defines.v: `RstEnable, `ZeroWord, stall/flush widths, state encodings WB_IDLE/WB_BUSY/WB_WAIT_FOR_STALL.
//  - Single module; no sub-module. One sequential always (state, wb regs, rd_buf, cnt, bus_err_o),
//    one combinational always (stallreq_o, cpu_data_o).
//  - Two instances in openmips_min_sopc: iwishbone (fetch) and dwishbone (MEM).
// TESTING
//  1 Read, zero-wait slave: ce=1,addr=0x100,we=0 -> cyc/stb=1 next cycle; ack w/ data 0xDEADBEEF ->
//    cpu_data_o=0xDEADBEEF, stallreq_o=0 in ack cycle, stb=0 after.
//  2 Write with 3 wait states: data=0x12345678, sel=4'b0011 -> wb outputs stable 4 cycles, stallreq=1
//    until ack, cpu_data_o=0 throughout.
//  3 Read acked while stall_i=6'b000111 -> WAIT_FOR_STALL, cpu_data_o holds rd_buf until stall_i=0, then IDLE.
//  4 flush_i=1 in BUSY before ack -> stb/cyc=0 next cycle, IDLE, no bus_err_o; flush+ack same cycle -> ack honoured.
//  5 TIMEOUT_CYC=4, slave never acks -> stb drops after 4 BUSY cycles, bus_err_o single pulse, stallreq_o=0.
//  6 rst=1 asserted in BUSY -> all wb_*_o=0, state IDLE next edge; late ack ignored.

Source files
------------

// File: rtl/wishbone_bus_if_pkg.sv
// Shared types and defaults for the pipeline-port to Wishbone classic bridge.
package wishbone_bus_if_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int STALL_W_DEF     = 6;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b10
    } wb_state_e;

    // Counter width covering 0 .. timeout-1; stays at least 1 bit wide.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc < 2) ? 1 : $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/wishbone_bus_if_if.sv
// Wishbone B.3 classic bus bundle; signal names follow the master's point of view.
interface wishbone_bus_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_we_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_stb_o;
    logic              wb_cyc_o;
    logic [DATA_W-1:0] wb_data_i;
    logic              wb_ack_i;

    modport master (
        output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/wishbone_bus_if.sv
// Bridges one CPU memory port to a Wishbone classic master; registered bus outputs, read data
// forwarded in the ack cycle; holds the pipeline via stallreq_o until ack, flush or watchdog timeout.
module wishbone_bus_if
    import wishbone_bus_if_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int STALL_W     = STALL_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic                bus_err_o,
    wishbone_bus_if_if.master   wb
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_we_q, wb_we_d;
    logic [SEL_W-1:0]  wb_sel_q, wb_sel_d;
    logic              wb_stb_q, wb_stb_d;
    logic              wb_cyc_q, wb_cyc_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;

    logic start_req;
    logic timeout_hit;

    // No new request in the error-pulse cycle: the pipeline is released and moves past this access.
    assign start_req   = cpu_ce_i & ~flush_i & ~bus_err_q;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        wb_sel_d   = wb_sel_q;
        wb_stb_d   = wb_stb_q;
        wb_cyc_d   = wb_cyc_q;
        rd_buf_d   = rd_buf_q;
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = '0;

        case (state_q)
            WB_IDLE: begin
                stallreq_o = start_req;
                if (start_req) begin
                    wb_addr_d = cpu_addr_i;
                    wb_data_d = cpu_data_i;
                    wb_we_d   = cpu_we_i;
                    wb_sel_d  = cpu_sel_i;
                    wb_stb_d  = 1'b1;
                    wb_cyc_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = WB_BUSY;
                end
            end

            WB_BUSY: begin
                if (wb.wb_ack_i) begin
                    wb_addr_d = '0;
                    wb_data_d = '0;
                    wb_we_d   = 1'b0;
                    wb_sel_d  = '0;
                    wb_stb_d  = 1'b0;
                    wb_cyc_d  = 1'b0;
                    if (!wb_we_q) begin
                        rd_buf_d   = wb.wb_data_i;
                        cpu_data_o = wb.wb_data_i;
                    end
                    state_d = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (flush_i || timeout_hit) begin
                        wb_addr_d = '0;
                        wb_data_d = '0;
                        wb_we_d   = 1'b0;
                        wb_sel_d  = '0;
                        wb_stb_d  = 1'b0;
                        wb_cyc_d  = 1'b0;
                        rd_buf_d  = '0;
                        state_d   = WB_IDLE;
                        bus_err_d = ~flush_i;
                    end
                end
            end

            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
                if (stall_i == '0) begin
                    state_d = WB_IDLE;
                end
            end

            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WB_IDLE;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_sel_q  <= '0;
            wb_stb_q  <= 1'b0;
            wb_cyc_q  <= 1'b0;
            rd_buf_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            wb_sel_q  <= wb_sel_d;
            wb_stb_q  <= wb_stb_d;
            wb_cyc_q  <= wb_cyc_d;
            rd_buf_q  <= rd_buf_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wb.wb_addr_o = wb_addr_q;
    assign wb.wb_data_o = wb_data_q;
    assign wb.wb_we_o   = wb_we_q;
    assign wb.wb_sel_o  = wb_sel_q;
    assign wb.wb_stb_o  = wb_stb_q;
    assign wb.wb_cyc_o  = wb_cyc_q;
    assign bus_err_o    = bus_err_q;

endmodule
